// File: rtl/affine_write_gen.sv
// Two-dimensional affine write-address generator: assigns each accepted data beat
// the address offset + x*x_stride + y*y_stride (x innermost) and issues one buffer write.
module affine_write_gen #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       offset,
    input  logic [15:0]       x_max,
    input  logic [15:0]       x_stride,
    input  logic [15:0]       y_max,
    input  logic [15:0]       y_stride,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [15:0]       wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state_q;
    logic [15:0]         offset_q, x_max_q, x_stride_q, y_max_q, y_stride_q;
    logic [15:0]         x_cnt_q, y_cnt_q, x_acc_q, y_acc_q;
    logic                in_ready_q, wr_en_q, busy_q, done_q;
    logic [15:0]         wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;

    logic                accept;
    logic                x_last, y_last;
    logic [15:0]         wr_addr_d;

    always_comb begin
        accept    = in_valid && in_ready_q;
        x_last    = (x_cnt_q == x_max_q - 16'd1);
        y_last    = (y_cnt_q == y_max_q - 16'd1);
        wr_addr_d = offset_q + x_acc_q + y_acc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            offset_q   <= '0;
            x_max_q    <= '0;
            x_stride_q <= '0;
            y_max_q    <= '0;
            y_stride_q <= '0;
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            x_acc_q    <= '0;
            y_acc_q    <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        offset_q   <= offset;
                        x_max_q    <= x_max;
                        x_stride_q <= x_stride;
                        y_max_q    <= y_max;
                        y_stride_q <= y_stride;
                        x_cnt_q    <= '0;
                        y_cnt_q    <= '0;
                        x_acc_q    <= '0;
                        y_acc_q    <= '0;
                        busy_q     <= 1'b1;
                        // An empty extent skips RUN entirely and only pulses done.
                        if (x_max == 16'd0 || y_max == 16'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= RUN;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= wr_addr_d;
                        wr_data_q <= in_data;
                        if (x_last && y_last) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            in_ready_q <= 1'b0;
                        end else if (!x_last) begin
                            x_cnt_q <= x_cnt_q + 16'd1;
                            x_acc_q <= x_acc_q + x_stride_q;
                        end else begin
                            x_cnt_q <= '0;
                            x_acc_q <= '0;
                            y_cnt_q <= y_cnt_q + 16'd1;
                            y_acc_q <= y_acc_q + y_stride_q;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_affine_write_gen.sv
// Randomized bench for affine_write_gen: expected write sequences come from nested
// x/y loops over the configured extents, compared beat by beat against the DUT.
module tb_affine_write_gen;

    localparam int unsigned DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst, start, in_valid;
    logic [15:0]       offset, x_max, x_stride, y_max, y_stride;
    logic [DATA_W-1:0] in_data;
    logic              in_ready, wr_en, busy, done;
    logic [15:0]       wr_addr;
    logic [DATA_W-1:0] wr_data;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    affine_write_gen #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .offset   (offset),
        .x_max    (x_max),
        .x_stride (x_stride),
        .y_max    (y_max),
        .y_stride (y_stride),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_cfg();
        offset   = 16'($urandom);
        x_max    = 16'($urandom);
        x_stride = 16'($urandom);
        y_max    = 16'($urandom);
        y_stride = 16'($urandom);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".wr_en"},    32'(wr_en),    32'd0);
        check({tag, ".busy"},     32'(busy),     32'd0);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        check({tag, ".done"},     32'(done),     32'd0);
    endtask

    // mode: 0 = valid always high, 1 = valid pattern 1,0,0 repeating, 2 = random valid
    task automatic run_transfer(input string tag, input logic [15:0] off, input logic [15:0] xm,
                                input logic [15:0] xs, input logic [15:0] ym, input logic [15:0] ys,
                                input int mode, input bit seq_data, input bit poke_start);
        logic [15:0]       exp_addr[$];
        logic [DATA_W-1:0] exp_data[$];
        logic [15:0]       a;
        int                n, k, cyc;
        bit                v;
        for (int y = 0; y < int'(ym); y++)
            for (int x = 0; x < int'(xm); x++) begin
                a = 16'(int'(off) + x * int'(xs) + y * int'(ys));
                exp_addr.push_back(a);
                exp_data.push_back(seq_data ? DATA_W'(exp_addr.size()) : DATA_W'($urandom));
            end
        n = exp_addr.size();

        offset = off; x_max = xm; x_stride = xs; y_max = ym; y_stride = ys;
        start = 1'b1; in_valid = 1'b0;
        step();
        start = 1'b0;
        scramble_cfg();
        check({tag, ".busy_after_start"}, 32'(busy), 32'd1);
        if (n == 0) begin
            check({tag, ".zero.done"},     32'(done),     32'd1);
            check({tag, ".zero.in_ready"}, 32'(in_ready), 32'd0);
            check({tag, ".zero.wr_en"},    32'(wr_en),    32'd0);
            step();
            check_idle({tag, ".zero.after"});
            return;
        end
        check({tag, ".in_ready_after_start"}, 32'(in_ready), 32'd1);
        check({tag, ".wr_en_after_start"},    32'(wr_en),    32'd0);

        k = 0;
        cyc = 0;
        while (k < n && cyc < 20 * n + 20) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 3 == 0);
                default: v = ($urandom_range(99) < 60);
            endcase
            in_valid = v;
            in_data  = v ? exp_data[k] : DATA_W'($urandom);
            start    = poke_start && (cyc == 2);
            if (start) offset = off ^ 16'h5A5A;
            step();
            start = 1'b0;
            if (v) begin
                check({tag, ".wr_en"},   32'(wr_en),   32'd1);
                check({tag, ".wr_addr"}, 32'(wr_addr), 32'(exp_addr[k]));
                check({tag, ".wr_data"}, 32'(wr_data), 32'(exp_data[k]));
                k++;
            end else begin
                check({tag, ".wr_en_gap"}, 32'(wr_en), 32'd0);
            end
            check({tag, ".done"},     32'(done),     32'(k == n));
            check({tag, ".in_ready"}, 32'(in_ready), 32'(k != n));
            check({tag, ".busy"},     32'(busy),     32'd1);
            cyc++;
        end
        if (k < n) check({tag, ".timeout_beats"}, 32'(k), 32'(n));
        in_valid = 1'b1;
        in_data  = DATA_W'($urandom);
        step();
        in_valid = 1'b0;
        check_idle({tag, ".end"});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        scramble_cfg();
        step();
        step();
        check_idle("reset");
        check("reset.wr_addr", 32'(wr_addr), 32'd0);
        check("reset.wr_data", 32'(wr_data), 32'd0);
        rst = 1'b0;
        step();

        run_transfer("basic",  16'd100,  16'd3, 16'd1, 16'd2, 16'd16, 0, 1'b1, 1'b0);
        run_transfer("bp",     16'd100,  16'd3, 16'd1, 16'd2, 16'd16, 1, 1'b1, 1'b0);
        run_transfer("wrap",   16'hFFF0, 16'd4, 16'd8, 16'd1, 16'd0,  0, 1'b0, 1'b0);
        run_transfer("zero_x", 16'd5,    16'd0, 16'd1, 16'd3, 16'd1,  0, 1'b0, 1'b0);
        run_transfer("zero_y", 16'd5,    16'd2, 16'd1, 16'd0, 16'd1,  0, 1'b0, 1'b0);
        run_transfer("sbusy",  16'd40,   16'd3, 16'd2, 16'd3, 16'd100, 0, 1'b0, 1'b1);

        // Reset after the fifth accept of a 4x4 transfer.
        offset = 16'd200; x_max = 16'd4; x_stride = 16'd1; y_max = 16'd4; y_stride = 16'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = DATA_W'(i);
            step();
        end
        check("rstmid.wr_addr5", 32'(wr_addr), 32'd210);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check_idle("rstmid");
        check("rstmid.wr_addr", 32'(wr_addr), 32'd0);
        run_transfer("after_rst", 16'd7, 16'd2, 16'd1, 16'd1, 16'd1, 0, 1'b0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            run_transfer("rand", 16'($urandom), 16'($urandom_range(5)), 16'($urandom),
                         16'($urandom_range(4)), 16'($urandom), 2, 1'b0, (t % 3 == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/affine_write_gen.md
# affine_write_gen

Two-dimensional affine write-address generator with a valid/ready data input. It is the writer-side counterpart of the affine read-address scanners. It accepts a stream of data beats, assigns each beat the address `offset + x*x_stride + y*y_stride` in row-major order (x innermost), and issues one buffer write per beat. Placed between an upstream producer and a buffer's write port, so data lands where the read-side scanner expects it.

## Interface
Parameters:
- DATA_W, 16, width of data beats and write data.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
- offset  input  16  base address; latched on accepted start.
- x_max  input  16  inner extent (beats per row); latched on accepted start.
- x_stride  input  16  address increment per inner step; latched.
- y_max  input  16  outer extent (rows); latched.
- y_stride  input  16  address increment per row; latched.
- in_valid  input  1  producer has a beat.
- in_data  input  DATA_W  beat payload.
- in_ready  output  1  block can accept a beat.
- wr_en  output  1  write strobe to buffer.
- wr_addr  output  16  write address.
- wr_data  output  DATA_W  write payload.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse at end of transfer.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=0, busy=0. On start=1, latch all five config inputs and clear x_cnt, y_cnt, x_acc, y_acc to 0. If latched x_max==0 or y_max==0, go to DONE with no writes. Otherwise go to RUN.
- RUN: in_ready=1. A beat is accepted when in_valid && in_ready.
- On accept, register wr_en=1, wr_addr=offset+x_acc+y_acc, and wr_data=in_data. Then advance the counters:
  - If x_cnt != x_max-1: x_cnt+=1 and x_acc+=x_stride.
  - Else: x_cnt=0, x_acc=0, y_cnt+=1, y_acc+=y_stride.
- Final beat is the accept with x_cnt==x_max-1 and y_cnt==y_max-1. Transition to DONE; the counters need not advance.
- DONE: lasts exactly one cycle. done=1, in_ready=0. Next state is IDLE.
- Arithmetic: all address math is 16-bit modulo 2^16; carries are discarded, with no saturation or error.
- start while busy is ignored; config changes during a transfer have no effect.
- No beat is ever dropped or duplicated: exactly x_max*y_max writes per transfer.

## Timing
- Reset values: state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0. Latched config, counters and accumulators are 0.
- Reset mid-transfer takes priority over everything. After the edge, all outputs are at reset values, including a pending wr_en, which is suppressed. There is no resume.
- Accepted start at edge N: busy=1 and in_ready=1 from cycle N+1.
- Beat accepted at edge N: wr_en/wr_addr/wr_data are valid in cycle N+1, so latency is 1. wr_en is otherwise 0.
- Full throughput: one beat per cycle when in_valid is held high. Gaps in in_valid produce matching gaps in wr_en.
- Final beat accepted at edge N: in cycle N+1, wr_en=1 for the last beat, done=1, busy=1 and in_ready=0. In cycle N+2 the block is in IDLE, busy=0, and can accept a new start.
- Zero-extent start at edge N: done=1 in cycle N+1 with wr_en=0 throughout.
- in_ready has no combinational dependence on in_valid.

## Test plan
- Basic 3x2 transfer: offset=100, x_max=3, x_stride=1, y_max=2, y_stride=16, and in_valid held high with data 1..6.
  - wr_addr sequence is 100, 101, 102, 116, 117, 118 on six consecutive cycles with data 1..6.
  - done is asserted with the sixth write; busy falls the cycle after.
- Backpressure: same config, in_valid toggling 1,0,0,1,... → the same six addresses in order; wr_en gaps match the in_valid gaps; exactly six writes.
- Wrap-around: offset=0xFFF0, x_max=4, x_stride=8, y_max=1 → addresses 0xFFF0, 0xFFF8, 0x0000, 0x0008, then done.
- Zero extent: start with x_max=0 → no wr_en; done pulses one cycle after start; in_ready stays 0.
- Reset mid-transfer: 4x4 config, assert rst after the 5th accept.
  - Next cycle: wr_en=0, busy=0, in_ready=0.
  - A new 2x1 transfer with offset=7, stride 1 then writes 7 and 8.
- Start while busy: a pulse of start with changed offset mid-transfer is ignored; the remaining addresses follow the original config and exactly one done is produced.
